// File: rtl/data_mem_resp.sv
// Data-memory responder: target end of the core's load/store port.
// Accepts one RV32I load/store at a time, waits WAIT_CYCLES, commits the
// access to a word-organised RAM and returns data or an error flag.
module data_mem_resp #(
  parameter int WIDTH       = 32,
  parameter int ADDR_BITS   = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [2:0]       req_funct3,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_rdata,
  output logic             rsp_err
);

  localparam int DEPTH = 2 ** ADDR_BITS;
  localparam int LANES = WIDTH / 8;
  localparam logic [3:0] CNT_MAX = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  state_t next_state;

  logic [3:0] cnt;

  // Request captured at the accept edge
  logic             lat_write;
  logic [2:0]       lat_funct3;
  logic [WIDTH-1:0] lat_addr;
  logic [WIDTH-1:0] lat_wdata;

  // Request the datapath works on: live inputs while idle (so a zero-wait
  // access can commit on its accept edge), the captured copy afterwards.
  logic             cur_write;
  logic [2:0]       cur_funct3;
  logic [WIDTH-1:0] cur_addr;
  logic [WIDTH-1:0] cur_wdata;

  logic                 accept;
  logic                 commit;
  logic [ADDR_BITS-1:0] word_idx;
  logic [1:0]           lane;
  logic                 misaligned;
  logic                 out_of_range;
  logic                 illegal;
  logic                 acc_err;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_word;
  logic [7:0]       byte_sel;
  logic [15:0]      half_sel;
  logic [WIDTH-1:0] load_data;
  logic [LANES-1:0] wr_be;
  logic [WIDTH-1:0] wr_data;

  assign accept = req_valid && req_ready;

  assign cur_write  = (state == IDLE) ? req_write  : lat_write;
  assign cur_funct3 = (state == IDLE) ? req_funct3 : lat_funct3;
  assign cur_addr   = (state == IDLE) ? req_addr   : lat_addr;
  assign cur_wdata  = (state == IDLE) ? req_wdata  : lat_wdata;

  // The edge that moves the FSM into RESP is the one that commits the access.
  assign commit = (next_state == RESP) && (state != RESP);

  // ---------------------------------------------------------------- FSM

  // State register
  // NOTE: every clocked process uses non-blocking assignments so all
  // registers sample pre-edge values and simulation matches the hardware.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic
  // NOTE: next_state gets a default before the case so every path assigns
  // it and no latch is inferred.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: if (accept) next_state = (WAIT_CYCLES > 0) ? WAIT : RESP;
      WAIT: if (cnt == CNT_MAX) next_state = RESP;
      RESP: if (rsp_valid && rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state
  always_comb begin
    req_ready = (state == IDLE);
    rsp_valid = (state == RESP);
  end

  // Wait-state counter: 1 on entry to WAIT, counts up to WAIT_CYCLES
  always_ff @(posedge clk) begin
    if (rst)                        cnt <= '0;
    else if (next_state != WAIT)    cnt <= '0;
    else if (state == WAIT)         cnt <= cnt + 4'd1;
    else                            cnt <= 4'd1;
  end

  // Capture the request on accept; later req_* changes are ignored
  always_ff @(posedge clk) begin
    if (accept) begin
      lat_write  <= req_write;
      lat_funct3 <= req_funct3;
      lat_addr   <= req_addr;
      lat_wdata  <= req_wdata;
    end
  end

  // ------------------------------------------------------ access decode

  assign word_idx = cur_addr[ADDR_BITS+1:2];
  assign lane     = cur_addr[1:0];

  assign out_of_range = |(cur_addr >> (ADDR_BITS + 2));

  // Alignment, range and funct3 legality of the current access
  always_comb begin
    if (cur_write) illegal = cur_funct3[2] || (cur_funct3[1:0] == 2'b11);
    else           illegal = (cur_funct3 == 3'b011) || (cur_funct3 == 3'b110) ||
                             (cur_funct3 == 3'b111);
    case (cur_funct3[1:0])
      2'b01:   misaligned = cur_addr[0];
      2'b10:   misaligned = |cur_addr[1:0];
      default: misaligned = 1'b0;
    endcase
    acc_err = illegal || misaligned || out_of_range;
  end

  // ------------------------------------------------------------- loads

  assign rd_word  = mem[word_idx];
  assign byte_sel = rd_word[{lane, 3'b000} +: 8];
  assign half_sel = rd_word[{lane[1], 4'b0000} +: 16];

  // Lane selection and sign/zero extension of load data
  always_comb begin
    case (cur_funct3)
      3'b000:  load_data = {{(WIDTH-8){byte_sel[7]}}, byte_sel};
      3'b001:  load_data = {{(WIDTH-16){half_sel[15]}}, half_sel};
      3'b010:  load_data = rd_word;
      3'b100:  load_data = {{(WIDTH-8){1'b0}}, byte_sel};
      3'b101:  load_data = {{(WIDTH-16){1'b0}}, half_sel};
      default: load_data = '0;
    endcase
  end

  // ------------------------------------------------------------ stores

  // Byte enables and lane-replicated store data
  always_comb begin
    wr_be   = '0;
    wr_data = cur_wdata;
    case (cur_funct3[1:0])
      2'b00: begin
        wr_data = {LANES{cur_wdata[7:0]}};
        for (int i = 0; i < LANES; i++) wr_be[i] = (2'(i) == lane);
      end
      2'b01: begin
        wr_data = {(LANES/2){cur_wdata[15:0]}};
        for (int i = 0; i < LANES; i++) wr_be[i] = (1'(i / 2) == lane[1]);
      end
      2'b10:   wr_be = '1;
      default: wr_be = '0;
    endcase
  end

  // RAM write on the commit edge of an error-free store
  // NOTE: the RAM array is deliberately not reset; contents survive rst so
  // it can map onto block RAM, and only the control path is reset.
  always_ff @(posedge clk) begin
    if (!rst && commit && cur_write && !acc_err) begin
      for (int i = 0; i < LANES; i++) begin
        if (wr_be[i]) mem[word_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  // ---------------------------------------------------------- response

  // Response payload: loaded on commit, held in RESP, cleared on handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (commit) begin
      rsp_err   <= acc_err;
      rsp_rdata <= (cur_write || acc_err) ? '0 : load_data;
    end else if (rsp_valid && rsp_ready) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_data_mem_resp.sv
// Bench for data_mem_resp: directed steps plus random accesses against a
// byte-array reference model. Instance a has one wait state, instance b three.
module tb_data_mem_resp;

  logic        clk = 1'b0;
  logic        rst_a, rst_b;
  logic        req_valid_a, req_valid_b;
  logic        req_ready_a, req_ready_b;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid_a, rsp_valid_b;
  logic        rsp_ready;
  logic [31:0] rsp_rdata_a, rsp_rdata_b;
  logic        rsp_err_a, rsp_err_b;

  int checks   = 0;
  int failures = 0;

  // Reference byte memory (only the prefilled low region is ever read)
  logic [7:0] mm [4096];

  always #5 clk = ~clk;

  data_mem_resp #(.WIDTH(32), .ADDR_BITS(10), .WAIT_CYCLES(1)) dut_a (
    .clk(clk), .rst(rst_a),
    .req_valid(req_valid_a), .req_ready(req_ready_a),
    .req_write(req_write), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata_a), .rsp_err(rsp_err_a)
  );

  data_mem_resp #(.WIDTH(32), .ADDR_BITS(10), .WAIT_CYCLES(3)) dut_b (
    .clk(clk), .rst(rst_b),
    .req_valid(req_valid_b), .req_ready(req_ready_b),
    .req_write(req_write), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata_b), .rsp_err(rsp_err_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic rdy(input bit sel);
    return sel ? req_ready_b : req_ready_a;
  endfunction

  function automatic logic vld(input bit sel);
    return sel ? rsp_valid_b : rsp_valid_a;
  endfunction

  function automatic logic [31:0] rdat(input bit sel);
    return sel ? rsp_rdata_b : rsp_rdata_a;
  endfunction

  function automatic logic erro(input bit sel);
    return sel ? rsp_err_b : rsp_err_a;
  endfunction

  // ---------------------------------------------------- reference model

  function automatic int acc_size(input logic [2:0] f3);
    return 1 << int'(f3[1:0]);
  endfunction

  function automatic bit model_err(input bit wr, input logic [2:0] f3, input logic [31:0] a);
    if (wr && f3 > 3'd2) return 1'b1;
    if (!wr && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) return 1'b1;
    if (a % acc_size(f3) != 0) return 1'b1;
    if (a >= 32'd4096) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
    int unsigned v = 0;
    int sz = acc_size(f3);
    for (int i = sz - 1; i >= 0; i--) v = (v << 8) | 32'(mm[a + 32'(i)]);
    if (f3[2] == 1'b0 && sz < 4 && v >= (32'd1 << (8 * sz - 1)))
      v = v - (32'd1 << (8 * sz));
    return v;
  endfunction

  task automatic model_apply(input bit wr, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd);
    if (wr && !model_err(wr, f3, a))
      for (int i = 0; i < acc_size(f3); i++) mm[a + 32'(i)] = 8'((wd >> (8 * i)) & 32'hFF);
  endtask

  // -------------------------------------------------------- bus driver

  // One full transaction: accept, latency, hold under back-pressure, release.
  task automatic access(input bit sel, input bit wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd, input int hold,
                        input logic [31:0] exp_rd, input logic exp_er, input string tag);
    int n;
    int lat;
    @(negedge clk);
    req_write  = wr;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    rsp_ready  = (hold == 0);
    if (sel) req_valid_b = 1'b1; else req_valid_a = 1'b1;
    n = 0;
    while (!rdy(sel) && n < 100) begin @(negedge clk); n++; end
    check({tag, " accept_timeout"}, 32'(n < 100), 32'd1);
    @(negedge clk);
    req_valid_a = 1'b0;
    req_valid_b = 1'b0;
    req_write   = 1'($urandom);
    req_funct3  = 3'($urandom);
    req_addr    = $urandom;
    req_wdata   = $urandom;
    lat = 1;
    while (!vld(sel) && lat < 100) begin @(negedge clk); lat++; end
    check({tag, " latency"}, 32'(lat), sel ? 32'd4 : 32'd2);
    check({tag, " rdata"}, rdat(sel), exp_rd);
    check({tag, " err"}, 32'(erro(sel)), 32'(exp_er));
    check({tag, " req_ready_in_resp"}, 32'(rdy(sel)), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, " hold_valid"}, 32'(vld(sel)), 32'd1);
      check({tag, " hold_rdata"}, rdat(sel), exp_rd);
      check({tag, " hold_err"}, 32'(erro(sel)), 32'(exp_er));
      check({tag, " hold_req_ready"}, 32'(rdy(sel)), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check({tag, " released_valid"}, 32'(vld(sel)), 32'd0);
    check({tag, " released_ready"}, 32'(rdy(sel)), 32'd1);
  endtask

  // Access on instance a with explicit expected values; model kept in step.
  task automatic dir_a(input bit wr, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input int hold, input logic [31:0] exp_rd,
                       input logic exp_er, input string tag);
    access(1'b0, wr, f3, addr, wd, hold, exp_rd, exp_er, tag);
    model_apply(wr, f3, addr, wd);
  endtask

  // Access on instance a with expectations taken from the model.
  task automatic op_a(input bit wr, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wd, input int hold, input string tag);
    logic        e_er;
    logic [31:0] e_rd;
    e_er = model_err(wr, f3, addr);
    e_rd = (wr || e_er) ? 32'd0 : model_load(f3, addr);
    access(1'b0, wr, f3, addr, wd, hold, e_rd, e_er, tag);
    model_apply(wr, f3, addr, wd);
  endtask

  // ----------------------------------------------------------- sequence

  initial begin
    logic        r_wr;
    logic [2:0]  r_f3;
    logic [31:0] r_addr;

    rst_a = 1'b1; rst_b = 1'b1;
    req_valid_a = 1'b0; req_valid_b = 1'b0;
    req_write = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
    rsp_ready = 1'b1;

    // Reset, then idle
    repeat (2) @(negedge clk);
    check("reset req_ready", 32'(req_ready_a), 32'd1);
    check("reset rsp_valid", 32'(rsp_valid_a), 32'd0);
    check("reset rsp_rdata", rsp_rdata_a, 32'd0);
    check("reset rsp_err", 32'(rsp_err_a), 32'd0);
    check("reset_b req_ready", 32'(req_ready_b), 32'd1);
    check("reset_b rsp_valid", 32'(rsp_valid_b), 32'd0);
    rst_a = 1'b0; rst_b = 1'b0;
    @(negedge clk);

    // Prefill bytes 0..63 so every later load reads defined data
    for (int w = 0; w < 16; w++) op_a(1'b1, 3'd2, 32'(w * 4), $urandom, 0, "prefill");

    // SW/LW round trip
    dir_a(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 0, 32'h0, 1'b0, "sw_10");
    dir_a(1'b0, 3'd2, 32'h10, 32'h0, 0, 32'hDEADBEEF, 1'b0, "lw_10");

    // Byte/half lanes and extension
    dir_a(1'b1, 3'd2, 32'h20, 32'h11223344, 0, 32'h0, 1'b0, "sw_20");
    dir_a(1'b1, 3'd0, 32'h21, 32'h000000F0, 0, 32'h0, 1'b0, "sb_21");
    dir_a(1'b0, 3'd2, 32'h20, 32'h0, 0, 32'h1122F044, 1'b0, "lw_20");
    dir_a(1'b0, 3'd0, 32'h21, 32'h0, 0, 32'hFFFFFFF0, 1'b0, "lb_21");
    dir_a(1'b0, 3'd4, 32'h21, 32'h0, 0, 32'h000000F0, 1'b0, "lbu_21");
    dir_a(1'b0, 3'd1, 32'h22, 32'h0, 0, 32'h00001122, 1'b0, "lh_22");
    dir_a(1'b1, 3'd1, 32'h22, 32'h00008001, 0, 32'h0, 1'b0, "sh_22");
    dir_a(1'b0, 3'd1, 32'h22, 32'h0, 0, 32'hFFFF8001, 1'b0, "lh_22_neg");
    dir_a(1'b0, 3'd5, 32'h22, 32'h0, 0, 32'h00008001, 1'b0, "lhu_22");

    // Errors
    dir_a(1'b0, 3'd2, 32'h11, 32'h0, 0, 32'h0, 1'b1, "lw_misaligned");
    dir_a(1'b1, 3'd1, 32'h13, 32'h0000CAFE, 0, 32'h0, 1'b1, "sh_misaligned");
    dir_a(1'b0, 3'd2, 32'h10, 32'h0, 0, 32'hDEADBEEF, 1'b0, "lw_10_unchanged");
    dir_a(1'b0, 3'd2, 32'h1000, 32'h0, 0, 32'h0, 1'b1, "lw_out_of_range");
    dir_a(1'b1, 3'd2, 32'h1010, 32'h12345678, 0, 32'h0, 1'b1, "sw_out_of_range");
    dir_a(1'b0, 3'd3, 32'h10, 32'h0, 0, 32'h0, 1'b1, "ld_funct3_011");
    dir_a(1'b1, 3'd4, 32'h10, 32'h0, 0, 32'h0, 1'b1, "st_funct3_100");
    dir_a(1'b0, 3'd2, 32'h10, 32'h0, 0, 32'hDEADBEEF, 1'b0, "lw_10_after_errs");

    // Back-pressure: response held for 5 cycles
    dir_a(1'b0, 3'd2, 32'h10, 32'h0, 5, 32'hDEADBEEF, 1'b0, "lw_backpressure");

    // Random accesses against the model
    for (int k = 0; k < 80; k++) begin
      r_wr = 1'($urandom);
      r_f3 = 3'($urandom);
      if ($urandom_range(0, 9) == 0) r_addr = $urandom | 32'h1000;
      else                           r_addr = 32'($urandom_range(0, 63));
      op_a(r_wr, r_f3, r_addr, $urandom, $urandom_range(0, 2), "random");
    end

    // Reset mid-access on the three-wait-state instance
    access(1'b1, 1'b1, 3'd2, 32'h30, 32'h0, 0, 32'h0, 1'b0, "b_sw_30_zero");
    @(negedge clk);
    req_write = 1'b1; req_funct3 = 3'd2; req_addr = 32'h30; req_wdata = 32'hAAAA5555;
    req_valid_b = 1'b1;
    check("b_abort accept_ready", 32'(req_ready_b), 32'd1);
    @(negedge clk);
    req_valid_b = 1'b0;
    check("b_abort wait1_ready", 32'(req_ready_b), 32'd0);
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    rst_b = 1'b0;
    check("b_abort idle_ready", 32'(req_ready_b), 32'd1);
    check("b_abort no_valid", 32'(rsp_valid_b), 32'd0);
    check("b_abort rdata", rsp_rdata_b, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("b_abort stays_quiet", 32'(rsp_valid_b), 32'd0);
    end
    access(1'b1, 1'b0, 3'd2, 32'h30, 32'h0, 0, 32'h0, 1'b0, "b_lw_30_after_abort");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
